// File: rtl/instr_fetch.sv
// Instruction fetch sequencer: REQ -> ISSUE -> REQ/IDLE with memory timeout and overflow HALT.
// Latency: instr one cycle after memReady; backpressure: instrValid and instr hold until instrReady.
module instr_fetch #(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    input  logic [7:0]  pcAddress,
    input  logic [1:0]  flags,
    input  logic        zero,
    output logic        memReq,
    output logic [7:0]  memAddr,
    input  logic        memReady,
    input  logic [15:0] memData,
    output logic [15:0] instr,
    output logic        instrValid,
    input  logic        instrReady,
    output logic        pcStep,
    output logic        sigBranch,
    output logic [7:0]  adding,
    output logic        halted,
    output logic [1:0]  fault
);

    typedef enum logic [1:0] {IDLE, REQ, ISSUE, HALT} state_t;

    localparam logic [3:0] TMO = 4'(TIMEOUT);

    state_t     state, state_nxt;
    logic [3:0] wait_cnt, wait_nxt;
    logic [7:0] addr_q;
    logic [1:0] fault_nxt;
    logic       xfer, take_branch, first_req, mem_timeout;

    // The backward-branch flag is informational only; it never steers the FSM.
    logic unused_flags;
    assign unused_flags = flags[0];

    always_comb begin
        xfer        = (state == ISSUE) && instrReady;
        take_branch = (instr[15:12] == 4'hC) || ((instr[15:12] == 4'hD) && zero);
        // wait_cnt is zero only on the first REQ cycle, which is when the PC is captured.
        first_req   = (state == REQ) && (wait_cnt == 4'd0);
        mem_timeout = (wait_cnt + 4'd1) == TMO;
        wait_nxt    = ((state == REQ) && !memReady) ? wait_cnt + 4'd1 : 4'd0;

        memReq      = (state == REQ);
        memAddr     = first_req ? pcAddress : addr_q;
        instrValid  = (state == ISSUE);
        pcStep      = xfer;
        sigBranch   = xfer && take_branch;
        adding      = sigBranch ? instr[7:0] : 8'h00;
        halted      = (state == HALT);
    end

    always_comb begin
        state_nxt = state;
        fault_nxt = fault;
        case (state)
            IDLE: begin
                if (run) state_nxt = REQ;
            end
            REQ: begin
                if (memReady) begin
                    state_nxt = ISSUE;
                end else if (mem_timeout) begin
                    state_nxt = HALT;
                    fault_nxt = 2'b10;
                end
            end
            ISSUE: begin
                if (xfer) begin
                    if (flags[1]) begin
                        state_nxt = HALT;
                        fault_nxt = 2'b01;
                    end else if (run) begin
                        state_nxt = REQ;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            HALT:    state_nxt = HALT;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            wait_cnt <= 4'd0;
            addr_q   <= 8'h00;
            instr    <= 16'h0000;
            fault    <= 2'b00;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
            fault    <= fault_nxt;
            if (first_req)
                addr_q <= pcAddress;
            if ((state == REQ) && memReady)
                instr <= memData;
        end
    end

endmodule
